// File: rtl/fp_simd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_simd_arbiter
// Brief    : Round-robin front end that shares one FP_SIMD engine among
//            NUM_REQ requesters. It accepts one request at a time, launches
//            it on the engine, waits for a result or a timeout, and returns
//            the result through a valid/ready response channel.
// Ports    : clk, rst           - rising-edge clock, synchronous active-high reset
//            req_valid/ready    - per-requester request handshake (ready one-hot)
//            req_opcode/in1/in2 - per-requester operands, requester r in slice r
//            resp_*             - response channel (id, data, error flag)
//            fp_*               - connection to the FP_SIMD engine
// Opcodes  : 3'd0 add, 3'd1 sub, 3'd2 mul, 3'd3 reduce_add; all others illegal
// Revision : 1.0 - initial release
// ============================================================================
module fp_simd_arbiter #(
    parameter int SIMD_WIDTH = 4,
    parameter int FP_W       = 22,
    parameter int NUM_REQ    = 3,
    parameter int TIMEOUT    = 32,
    localparam int c_ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int c_DATA_W  = SIMD_WIDTH * FP_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*3-1:0]          req_opcode,
    input  logic [NUM_REQ*c_DATA_W-1:0]   req_in1,
    input  logic [NUM_REQ*c_DATA_W-1:0]   req_in2,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [c_ID_W-1:0]             resp_id,
    output logic [c_DATA_W-1:0]           resp_data,
    output logic                          resp_err,
    output logic                          fp_en,
    output logic [2:0]                    fp_opcode,
    output logic [c_DATA_W-1:0]           fp_in1,
    output logic [c_DATA_W-1:0]           fp_in2,
    input  logic [c_DATA_W-1:0]           fp_output,
    input  logic                          fp_valid,
    input  logic                          fp_busy
);

    localparam logic [2:0] c_OP_ADD        = 3'd0;
    localparam logic [2:0] c_OP_SUB        = 3'd1;
    localparam logic [2:0] c_OP_MUL        = 3'd2;
    localparam logic [2:0] c_OP_REDUCE_ADD = 3'd3;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_EXEC = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

    localparam int c_CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_ID_W-1:0]  c_LAST_RST = c_ID_W'(NUM_REQ - 1);

    logic [1:0]          r_state;
    logic [c_ID_W-1:0]   r_last_grant;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_ID_W-1:0]   r_id;
    logic [2:0]          r_opcode;
    logic [c_DATA_W-1:0] r_in1;
    logic [c_DATA_W-1:0] r_in2;
    logic [c_DATA_W-1:0] r_resp_data;
    logic                r_resp_err;
    logic                r_fp_en;

    logic                w_found;
    logic [c_ID_W-1:0]   w_winner;
    logic                w_grant;
    logic [2:0]          w_win_opcode;
    logic                w_op_legal;

    // Round-robin search: first valid requester at or after last_grant+1.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[(int'(r_last_grant) + 1 + i) % NUM_REQ]) begin
                w_found  = 1'b1;
                w_winner = c_ID_W'((int'(r_last_grant) + 1 + i) % NUM_REQ);
            end
        end
    end

    // Gated by rst so a requester never sees an accept that is then discarded.
    assign w_grant      = (r_state == c_S_IDLE) && !fp_busy && w_found && !rst;
    assign w_win_opcode = req_opcode[int'(w_winner)*3 +: 3];
    assign w_op_legal   = (w_win_opcode == c_OP_ADD) || (w_win_opcode == c_OP_SUB) ||
                          (w_win_opcode == c_OP_MUL) || (w_win_opcode == c_OP_REDUCE_ADD);

    generate
        for (genvar r = 0; r < NUM_REQ; r++) begin : g_ready
            assign req_ready[r] = w_grant && (w_winner == c_ID_W'(r));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_S_IDLE;
            r_last_grant <= c_LAST_RST;
            r_cnt        <= '0;
            r_id         <= '0;
            r_opcode     <= '0;
            r_in1        <= '0;
            r_in2        <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_fp_en      <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_grant) begin
                        r_last_grant <= w_winner;
                        r_id         <= w_winner;
                        r_opcode     <= w_win_opcode;
                        r_in1        <= req_in1[int'(w_winner)*c_DATA_W +: c_DATA_W];
                        r_in2        <= req_in2[int'(w_winner)*c_DATA_W +: c_DATA_W];
                        r_cnt        <= '0;
                        r_resp_data  <= '0;
                        if (w_op_legal) begin
                            r_state    <= c_S_EXEC;
                            r_fp_en    <= 1'b1;
                            r_resp_err <= 1'b0;
                        end else begin
                            // Illegal opcode never reaches the engine.
                            r_state    <= c_S_RESP;
                            r_fp_en    <= 1'b0;
                            r_resp_err <= 1'b1;
                        end
                    end
                end
                c_S_EXEC: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A result arriving on the last allowed cycle still counts.
                    if (fp_valid) begin
                        r_resp_data <= fp_output;
                        r_resp_err  <= 1'b0;
                        r_fp_en     <= 1'b0;
                        r_state     <= c_S_RESP;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_resp_data <= '0;
                        r_resp_err  <= 1'b1;
                        r_fp_en     <= 1'b0;
                        r_state     <= c_S_RESP;
                    end
                end
                c_S_RESP: begin
                    if (resp_ready) begin
                        r_state <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_fp_en <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid = (r_state == c_S_RESP);
    assign resp_id    = r_id;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
    assign fp_en      = r_fp_en;
    assign fp_opcode  = r_opcode;
    assign fp_in1     = r_in1;
    assign fp_in2     = r_in2;

endmodule
`default_nettype wire

// File: tb/tb_fp_simd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_simd_arbiter
// Brief    : Directed self-checking bench for fp_simd_arbiter with a small
//            behavioural FP_SIMD stand-in that returns a preset result after
//            a programmable number of fp_en cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_simd_arbiter;

    localparam int c_SIMD = 4;
    localparam int c_FPW  = 22;
    localparam int c_NREQ = 3;
    localparam int c_TO   = 32;
    localparam int c_DW   = c_SIMD * c_FPW;

    // 22-bit float: sign[21], exponent[20:13] bias 127, mantissa[12:0]
    localparam logic [21:0] c_FP_HALF      = 22'h0FC000;
    localparam logic [21:0] c_FP_ONE       = 22'h0FE000;
    localparam logic [21:0] c_FP_ONEHALF   = 22'h0FF000;
    localparam logic [21:0] c_FP_TWO       = 22'h100000;
    localparam logic [21:0] c_FP_TWOHALF   = 22'h100800;
    localparam logic [21:0] c_FP_THREE     = 22'h101000;
    localparam logic [21:0] c_FP_THREEHALF = 22'h101800;
    localparam logic [21:0] c_FP_FOUR      = 22'h102000;

    localparam logic [c_DW-1:0] c_VEC_A   = {c_FP_ONE, c_FP_TWO, c_FP_TWOHALF, c_FP_THREE};
    localparam logic [c_DW-1:0] c_VEC_B   = {c_FP_HALF, c_FP_TWO, c_FP_ONE, c_FP_ONE};
    localparam logic [c_DW-1:0] c_ADD_RES = {c_FP_ONEHALF, c_FP_FOUR, c_FP_THREEHALF, c_FP_FOUR};
    localparam logic [c_DW-1:0] c_MUL_RES = {c_FP_HALF, c_FP_FOUR, c_FP_TWOHALF, c_FP_THREE};
    localparam logic [c_DW-1:0] c_SUB_RES = {c_FP_HALF, 22'h0, c_FP_ONEHALF, c_FP_TWO};

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_MUL = 3'd2;
    localparam logic [2:0] c_OP_BAD = 3'b111;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [c_NREQ-1:0]      req_valid;
    logic [c_NREQ-1:0]      req_ready;
    logic [c_NREQ*3-1:0]    req_opcode;
    logic [c_NREQ*c_DW-1:0] req_in1;
    logic [c_NREQ*c_DW-1:0] req_in2;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [1:0]             resp_id;
    logic [c_DW-1:0]        resp_data;
    logic                   resp_err;
    logic                   fp_en;
    logic [2:0]             fp_opcode;
    logic [c_DW-1:0]        fp_in1;
    logic [c_DW-1:0]        fp_in2;
    logic [c_DW-1:0]        fp_output = '0;
    logic                   fp_valid = 1'b0;
    logic                   fp_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Engine stand-in controls (written only by the stimulus block)
    int              m_delay  = 0;
    logic [c_DW-1:0] m_result = '0;
    bit              m_spur   = 1'b0;
    // Engine stand-in observations (written only by the model block)
    int              m_k        = 0;
    int              m_en_total = 0;
    int              m_unstable = 0;
    logic [2:0]      m_cap_op   = '0;
    logic [c_DW-1:0] m_cap_in1  = '0;
    logic [c_DW-1:0] m_cap_in2  = '0;

    fp_simd_arbiter #(
        .SIMD_WIDTH (c_SIMD),
        .FP_W       (c_FPW),
        .NUM_REQ    (c_NREQ),
        .TIMEOUT    (c_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .fp_en      (fp_en),
        .fp_opcode  (fp_opcode),
        .fp_in1     (fp_in1),
        .fp_in2     (fp_in2),
        .fp_output  (fp_output),
        .fp_valid   (fp_valid),
        .fp_busy    (fp_busy)
    );

    always #5 clk = ~clk;

    // Engine stand-in: fp_valid during the m_delay-th enabled cycle (0-based).
    always @(negedge clk) begin
        if (fp_en) begin
            if (m_k == 0) begin
                m_cap_op  = fp_opcode;
                m_cap_in1 = fp_in1;
                m_cap_in2 = fp_in2;
            end else if (fp_opcode !== m_cap_op || fp_in1 !== m_cap_in1 || fp_in2 !== m_cap_in2) begin
                m_unstable++;
            end
            fp_valid  = (m_k == m_delay);
            fp_output = m_result;
            m_k++;
            m_en_total++;
        end else begin
            m_k      = 0;
            fp_valid = m_spur;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [c_DW-1:0] obs, input logic [c_DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [2:0] op, input logic [c_DW-1:0] a, input logic [c_DW-1:0] b);
        req_opcode[r*3 +: 3]     = op;
        req_in1[r*c_DW +: c_DW]  = a;
        req_in2[r*c_DW +: c_DW]  = b;
    endtask

    task automatic wait_grant(output int who);
        who = -1;
        for (int i = 0; i < 50; i++) begin
            if (req_ready != '0) begin
                case (req_ready)
                    3'b001:  who = 0;
                    3'b010:  who = 1;
                    3'b100:  who = 2;
                    default: who = -2;
                endcase
                break;
            end
            tick;
            #1;
        end
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (!resp_valid && n < 100) begin
            tick;
            #1;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int who;
        int n;
        int base;

        rst        = 1'b1;
        req_valid  = '0;
        req_opcode = '0;
        req_in1    = '0;
        req_in2    = '0;
        resp_ready = 1'b1;
        fp_busy    = 1'b0;
        repeat (3) tick;
        #1;
        check("rst_resp_valid", c_DW'(resp_valid), 0);
        check("rst_fp_en",      c_DW'(fp_en), 0);
        check("rst_req_ready",  c_DW'(req_ready), 0);
        check("rst_resp_data",  resp_data, 0);
        check("rst_resp_id",    c_DW'(resp_id), 0);
        check("rst_resp_err",   c_DW'(resp_err), 0);
        check("rst_fp_opcode",  c_DW'(fp_opcode), 0);
        check("rst_fp_in1",     fp_in1, 0);
        tick;
        rst = 1'b0;
        #1;

        // Single add from requester 0
        base     = m_en_total;
        m_delay  = 2;
        m_result = c_ADD_RES;
        set_req(0, c_OP_ADD, c_VEC_A, c_VEC_B);
        req_valid = 3'b001;
        #1;
        check("add_grant", c_DW'(req_ready), 3'b001);
        tick;
        req_valid = '0;
        #1;
        check("add_fp_en",     c_DW'(fp_en), 1);
        check("add_fp_opcode", c_DW'(fp_opcode), c_DW'(c_OP_ADD));
        check("add_fp_in1",    fp_in1, c_VEC_A);
        check("add_fp_in2",    fp_in2, c_VEC_B);
        check("add_exec_ready", c_DW'(req_ready), 0);
        wait_resp(n);
        check("add_latency",  c_DW'(n), 3);
        check("add_resp_valid", c_DW'(resp_valid), 1);
        check("add_resp_id",  c_DW'(resp_id), 0);
        check("add_resp_err", c_DW'(resp_err), 0);
        check("add_resp_data", resp_data, c_ADD_RES);
        check("add_resp_fp_en", c_DW'(fp_en), 0);
        check("add_en_cycles", c_DW'(m_en_total - base), 3);
        tick;
        #1;
        check("add_after_hs", c_DW'(resp_valid), 0);

        // Three requesters contending with mul, starting from a fresh reset
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        m_delay  = 1;
        m_result = c_MUL_RES;
        for (int r = 0; r < 3; r++) set_req(r, c_OP_MUL, c_VEC_A, c_VEC_B);
        req_valid = 3'b111;
        #1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(who);
            check("rr_grant", c_DW'(who), c_DW'(k % 3));
            tick;
            if (k == 3) req_valid = '0;
            #1;
            check("rr_exec_no_ready", c_DW'(req_ready), 0);
            check("rr_fp_opcode", c_DW'(fp_opcode), c_DW'(c_OP_MUL));
            wait_resp(n);
            check("rr_resp_valid", c_DW'(resp_valid), 1);
            check("rr_resp_id", c_DW'(resp_id), c_DW'(k % 3));
            check("rr_resp_data", resp_data, c_MUL_RES);
            tick;
            #1;
        end

        // Sub from requester 1 with response backpressure
        m_delay  = 0;
        m_result = c_SUB_RES;
        set_req(1, c_OP_SUB, c_VEC_A, c_VEC_B);
        resp_ready = 1'b0;
        req_valid  = 3'b010;
        #1;
        wait_grant(who);
        check("sub_grant", c_DW'(who), 1);
        tick;
        req_valid = '0;
        #1;
        wait_resp(n);
        check("sub_latency", c_DW'(n), 1);
        set_req(0, c_OP_ADD, c_VEC_A, c_VEC_B);
        m_result  = c_ADD_RES;
        req_valid = 3'b001;
        for (int i = 0; i < 10; i++) begin
            tick;
            #1;
            check("bp_resp_valid", c_DW'(resp_valid), 1);
            check("bp_resp_data", resp_data, c_SUB_RES);
            check("bp_resp_id", c_DW'(resp_id), 1);
            check("bp_no_grant", c_DW'(req_ready), 0);
        end
        resp_ready = 1'b1;
        #1;
        check("bp_hold_until_edge", c_DW'(resp_valid), 1);
        tick;
        #1;
        check("bp_next_grant", c_DW'(req_ready), 3'b001);
        tick;
        req_valid = '0;
        #1;
        wait_resp(n);
        check("bp_next_id", c_DW'(resp_id), 0);
        check("bp_next_data", resp_data, c_ADD_RES);
        tick;
        #1;

        // Illegal opcode from requester 2
        base = m_en_total;
        set_req(2, c_OP_BAD, c_VEC_A, c_VEC_B);
        req_valid = 3'b100;
        #1;
        check("bad_grant", c_DW'(req_ready), 3'b100);
        tick;
        req_valid = '0;
        #1;
        check("bad_resp_valid", c_DW'(resp_valid), 1);
        check("bad_resp_err", c_DW'(resp_err), 1);
        check("bad_resp_id", c_DW'(resp_id), 2);
        check("bad_resp_data", resp_data, 0);
        check("bad_fp_en", c_DW'(fp_en), 0);
        tick;
        #1;
        check("bad_after_hs", c_DW'(resp_valid), 0);
        check("bad_en_cycles", c_DW'(m_en_total - base), 0);

        // Engine never answers: timeout after TIMEOUT enabled cycles
        base    = m_en_total;
        m_delay = -1;
        set_req(0, c_OP_ADD, c_VEC_A, c_VEC_B);
        req_valid = 3'b001;
        #1;
        check("to_grant", c_DW'(req_ready), 3'b001);
        tick;
        req_valid = '0;
        #1;
        wait_resp(n);
        check("to_cycles", c_DW'(n), c_DW'(c_TO));
        check("to_resp_err", c_DW'(resp_err), 1);
        check("to_resp_data", resp_data, 0);
        check("to_en_cycles", c_DW'(m_en_total - base), c_DW'(c_TO));
        tick;
        #1;

        // Engine answers on the last allowed cycle: result wins over timeout
        m_delay  = c_TO - 1;
        m_result = c_MUL_RES;
        set_req(1, c_OP_MUL, c_VEC_A, c_VEC_B);
        req_valid = 3'b010;
        #1;
        check("late_grant", c_DW'(req_ready), 3'b010);
        tick;
        req_valid = '0;
        #1;
        wait_resp(n);
        check("late_cycles", c_DW'(n), c_DW'(c_TO));
        check("late_resp_err", c_DW'(resp_err), 0);
        check("late_resp_data", resp_data, c_MUL_RES);
        tick;
        #1;

        // Engine busy blocks grants; stray fp_valid in IDLE is ignored
        fp_busy  = 1'b1;
        m_spur   = 1'b1;
        m_delay  = 0;
        m_result = c_ADD_RES;
        set_req(0, c_OP_ADD, c_VEC_A, c_VEC_B);
        req_valid = 3'b001;
        #1;
        check("busy_no_grant", c_DW'(req_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            #1;
            check("busy_no_grant_hold", c_DW'(req_ready), 0);
            check("spur_no_resp", c_DW'(resp_valid), 0);
        end
        m_spur  = 1'b0;
        fp_busy = 1'b0;
        #1;
        check("unbusy_grant", c_DW'(req_ready), 3'b001);
        tick;
        req_valid = '0;
        #1;
        wait_resp(n);
        check("unbusy_latency", c_DW'(n), 1);
        check("unbusy_resp_data", resp_data, c_ADD_RES);
        tick;
        #1;

        // Reset in the middle of an operation
        m_delay   = -1;
        req_valid = 3'b001;
        #1;
        check("mid_grant", c_DW'(req_ready), 3'b001);
        tick;
        req_valid = '0;
        tick;
        tick;
        #1;
        check("mid_fp_en", c_DW'(fp_en), 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        check("mid_rst_fp_en", c_DW'(fp_en), 0);
        check("mid_rst_resp_valid", c_DW'(resp_valid), 0);
        req_valid = 3'b111;
        #1;
        check("mid_rst_grant0", c_DW'(req_ready), 3'b001);
        m_delay = 0;
        tick;
        req_valid = '0;
        #1;
        wait_resp(n);
        check("mid_rst_resp_id", c_DW'(resp_id), 0);
        tick;
        #1;

        check("fp_inputs_stable", c_DW'(m_unstable), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
